present_round_engine: RTL and testbench

Iterative PRESENT-80 cipher datapath that sits directly downstream of the round-key scheduler. It accepts a 64-bit block and an 80-bit key over a valid/ready handshake. It runs the 31 PRESENT rounds one per clock, deriving each round key on the fly with the same rotate/S-box/counter-salt update the scheduler uses. It returns the result over a second valid/ready handshake, and an optional decryption path is compiled in by macro.

---
 rtl/present_pkg.sv | 78 +++++++
 rtl/present_sbox_layer.sv | 19 +
 rtl/present_round_engine.sv | 148 ++++++++++++++
 tb/tb_present_round_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, S-box tables, bit permutation,
// forward/inverse key-schedule steps and the engine FSM state type.
`ifndef KEY_SIZE
`define KEY_SIZE 80
`endif
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 31
`endif

package present_pkg;

  localparam int PRESENT_BLOCK_W = 64;
  localparam int PRESENT_KEY_W   = `KEY_SIZE;
  localparam int PRESENT_ROUNDS  = `NUM_ROUNDS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYGEN = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] perm(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[(16 * i) % 63] = x[i];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [63:0] perm_inv(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) r[i] = x[(16 * i) % 63];
    r[63] = x[63];
    return r;
  endfunction

  function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic [79:0] key_update_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = sbox4_inv(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_sbox_layer.sv
// 16 parallel PRESENT nibble substitutions; INVERSE picks S^-1 at elaboration.
module present_sbox_layer
  import present_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [63:0] in_i,
  output logic [63:0] out_o
);

  for (genvar n = 0; n < 16; n++) begin : g_nib
    if (INVERSE) begin : g_inv
      assign out_o[4*n +: 4] = sbox4_inv(in_i[4*n +: 4]);
    end else begin : g_fwd
      assign out_o[4*n +: 4] = sbox4(in_i[4*n +: 4]);
    end
  end

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT-80 engine, one round per clock with on-the-fly key schedule.
// Define PRESENT_DECRYPT_EN to build the in_decrypt port and the inverse datapath.
module present_round_engine
  import present_pkg::*;
#(
  parameter int BLOCK_W = PRESENT_BLOCK_W,
  parameter int KEY_W   = PRESENT_KEY_W,
  parameter int ROUNDS  = PRESENT_ROUNDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [KEY_W-1:0]   in_key,
`ifdef PRESENT_DECRYPT_EN
  input  logic               in_decrypt,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  state_e             st_q, st_d;
  logic [BLOCK_W-1:0] blk_q, blk_d, out_q, out_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [4:0]         rc_q, rc_d;

  logic [63:0] enc_sub, enc_next;
  logic [79:0] key_upd;

  present_sbox_layer #(.INVERSE(1'b0)) u_sbox_fwd (
    .in_i  (blk_q ^ key_q[79:16]),
    .out_o (enc_sub)
  );

  assign enc_next = perm(enc_sub);
  assign key_upd  = key_update(key_q, rc_q);

`ifdef PRESENT_DECRYPT_EN
  logic        dec_q, dec_d;
  logic [63:0] dec_sub, dec_next;
  logic [79:0] key_inv;

  present_sbox_layer #(.INVERSE(1'b1)) u_sbox_inv (
    .in_i  (perm_inv(blk_q)),
    .out_o (dec_sub)
  );

  assign key_inv  = key_update_inv(key_q, rc_q);
  assign dec_next = dec_sub ^ key_inv[79:16];
`endif

  always_comb begin
    st_d  = st_q;
    blk_d = blk_q;
    key_d = key_q;
    rc_d  = rc_q;
    out_d = out_q;
`ifdef PRESENT_DECRYPT_EN
    dec_d = dec_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d = in_block;
          key_d = in_key;
          rc_d  = 5'd1;
          st_d  = ST_RUN;
`ifdef PRESENT_DECRYPT_EN
          dec_d = in_decrypt;
          if (in_decrypt) st_d = ST_KEYGEN;
`endif
        end
      end
`ifdef PRESENT_DECRYPT_EN
      // Walk the schedule forward to K32, then strip the final whitening key.
      ST_KEYGEN: begin
        key_d = key_upd;
        if (rc_q == 5'(ROUNDS)) begin
          blk_d = blk_q ^ key_upd[79:16];
          st_d  = ST_RUN;
        end else begin
          rc_d = rc_q + 5'd1;
        end
      end
`endif
      ST_RUN: begin
`ifdef PRESENT_DECRYPT_EN
        if (dec_q) begin
          key_d = key_inv;
          blk_d = dec_next;
          if (rc_q == 5'd1) begin
            out_d = dec_next;
            st_d  = ST_DONE;
          end else begin
            rc_d = rc_q - 5'd1;
          end
        end else
`endif
        begin
          blk_d = enc_next;
          key_d = key_upd;
          // rc holds at its last value rather than wrapping to 0.
          if (rc_q == 5'(ROUNDS)) begin
            out_d = enc_next ^ key_upd[79:16];
            st_d  = ST_DONE;
          end else begin
            rc_d = rc_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      blk_q <= '0;
      key_q <= '0;
      rc_q  <= '0;
      out_q <= '0;
`ifdef PRESENT_DECRYPT_EN
      dec_q <= 1'b0;
`endif
    end else begin
      st_q  <= st_d;
      blk_q <= blk_d;
      key_q <= key_d;
      rc_q  <= rc_d;
      out_q <= out_d;
`ifdef PRESENT_DECRYPT_EN
      dec_q <= dec_d;
`endif
    end
  end

  assign in_ready  = (st_q == ST_IDLE);
  assign busy      = (st_q != ST_IDLE);
  assign out_valid = (st_q == ST_DONE);
  assign out_block = out_q;

endmodule

// File: tb/tb_present_round_engine.sv
// Self-checking bench for present_round_engine: known-answer table, handshake
// corner cases, reset abort, back-to-back streaming and random blocks vs a model.
module tb_present_round_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_block = '0;
  logic [79:0] in_key = '0;
`ifdef PRESENT_DECRYPT_EN
  logic        in_decrypt = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_block;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];

  present_round_engine dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_key     (in_key),
`ifdef PRESENT_DECRYPT_EN
    .in_decrypt (in_decrypt),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] rk [1:32];
    logic [63:0] s, u, t;
    k = key;
    for (int r = 1; r <= 32; r++) begin
      rk[r] = k[79:16];
      k = (k << 61) | (k >> 19);
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      u = s ^ rk[r];
      for (int n = 0; n < 16; n++) u[4*n +: 4] = SB[u[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = u[i];
      s = t;
    end
    return s ^ rk[32];
  endfunction

  // ---------------- checking and driver tasks ----------------
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] pt, input logic [79:0] key);
    int g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1; g++;
    end
    in_valid = 1'b1;
    in_block = pt;
    in_key   = key;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_enc(input string name, input logic [63:0] pt, input logic [79:0] key,
                         input logic [63:0] exp);
    int lat;
    send(pt, key);
    wait_out(lat);
    check({name, "_latency"}, 80'(lat), 80'd31);
    check({name, "_block"}, 80'(out_block), 80'(exp));
    take();
  endtask

  typedef struct {
    logic [79:0] key;
    logic [63:0] pt;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int          lat, seen;
    logic [63:0] held, pt;
    logic [79:0] key;
    logic [63:0] b2b_pt [4];
    logic [79:0] b2b_key [4];
    int          acc_cyc [4];
    int          sent, got;

    vecs[0] = '{key: 80'h0,                      pt: 64'h0,                exp: 64'h5579C1387B228445};
    vecs[1] = '{key: 80'hFFFFFFFFFFFFFFFFFFFF,   pt: 64'h0,                exp: 64'hE72C46C0F5945049};
    vecs[2] = '{key: 80'h0,                      pt: 64'hFFFFFFFFFFFFFFFF, exp: 64'hA112FFC72F68417B};
    vecs[3] = '{key: 80'hFFFFFFFFFFFFFFFFFFFF,   pt: 64'hFFFFFFFFFFFFFFFF, exp: 64'h3333DCD3213210D2};

    // clock / reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  80'(in_ready),  80'd1);
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_busy",      80'(busy),      80'd0);
    check("rst_out_block", 80'(out_block), 80'd0);

    // known-answer table
    for (int i = 0; i < 3; i++)
      run_enc($sformatf("kat%0d", i), vecs[i].pt, vecs[i].key, vecs[i].exp);

    // last vector with consumer stalled for 10 cycles
    send(vecs[3].pt, vecs[3].key);
    wait_out(lat);
    check("kat3_latency", 80'(lat), 80'd31);
    check("kat3_block", 80'(out_block), 80'(vecs[3].exp));
    held = out_block;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_block !== held || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
    end
    in_valid = 1'b0;
    check("stall_stable", 80'(seen), 80'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready",  80'(in_ready),  80'd1);
    check("release_out_valid", 80'(out_valid), 80'd0);

    // abort mid-run with reset
    send(64'h0123456789ABCDEF, 80'h13579BDF02468ACE1357);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy",      80'(busy),      80'd0);
    check("abort_in_ready",  80'(in_ready),  80'd1);
    check("abort_out_block", 80'(out_block), 80'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", 80'(seen), 80'd0);
    run_enc("after_abort", 64'h0, 80'h0, 64'h5579C1387B228445);

    // random blocks against the model
    for (int i = 0; i < 6; i++) begin
      pt  = {$urandom, $urandom};
      key = {16'($urandom), $urandom, $urandom};
      run_enc($sformatf("rand%0d", i), pt, key, ref_encrypt(pt, key));
    end

    // back-to-back: accept every 31 run cycles + 1 DONE + 1 IDLE
    for (int i = 0; i < 4; i++) begin
      b2b_pt[i]  = {$urandom, $urandom};
      b2b_key[i] = {16'($urandom), $urandom, $urandom};
      acc_cyc[i] = 0;
    end
    sent = 0;
    got  = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_block  = b2b_pt[0];
    in_key    = b2b_key[0];
    for (int c = 0; c < 400 && got < 4; c++) begin
      logic acc_now;
      acc_now = in_ready && in_valid;
      if (out_valid) begin
        if (exp_q.size() == 0) check("b2b_spurious", 80'd1, 80'd0);
        else check($sformatf("b2b_out%0d", got), 80'(out_block), 80'(exp_q.pop_front()));
        got++;
      end
      if (acc_now) begin
        exp_q.push_back(ref_encrypt(in_block, in_key));
        acc_cyc[sent] = c;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        sent++;
        if (sent == 4) in_valid = 1'b0;
        else begin
          in_block = b2b_pt[sent];
          in_key   = b2b_key[sent];
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", 80'(got), 80'd4);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b_interval%0d", i), 80'(acc_cyc[i] - acc_cyc[i-1]), 80'd33);

`ifdef PRESENT_DECRYPT_EN
    // decrypt known answer, with in_valid poked during KEYGEN
    in_decrypt = 1'b1;
    send(64'h5579C1387B228445, 80'h0);
    in_decrypt = 1'b0;
    seen = 0;
    in_valid = 1'b1;
    in_block = 64'hDEADBEEFDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      if (in_ready) seen++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("dec_keygen_in_ready", 80'(seen), 80'd0);
    lat = 5;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("dec_latency", 80'(lat), 80'd62);
    check("dec_block", 80'(out_block), 80'd0);
    take();
    for (int i = 0; i < 3; i++) begin
      pt  = {$urandom, $urandom};
      key = {16'($urandom), $urandom, $urandom};
      in_decrypt = 1'b1;
      send(ref_encrypt(pt, key), key);
      in_decrypt = 1'b0;
      wait_out(lat);
      check($sformatf("dec_rand%0d_latency", i), 80'(lat), 80'd62);
      check($sformatf("dec_rand%0d_block", i), 80'(out_block), 80'(pt));
      take();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
